// File: rtl/des_pkg.sv
// DES constants and pure helpers shared by the sequencer and the round datapath.
// Bit numbering: DES bit 1 is the MSB of every vector, so DES bit n of an
// N-bit vector lives at index N-n.
package des_pkg;

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int unsigned P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  // Each box is row-major: entry index = row*16 + col.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // SHIFT[1:16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
  function automatic logic [1:0] shift_of(logic [4:0] rnd);
    case (rnd)
      5'd1, 5'd2, 5'd9, 5'd16: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  function automatic logic [63:0] ip(logic [63:0] x);
    logic [63:0] res = '0;
    for (int i = 0; i < 64; i++) res[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return res;
  endfunction

  function automatic logic [63:0] fp(logic [63:0] x);
    logic [63:0] res = '0;
    for (int i = 0; i < 64; i++) res[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return res;
  endfunction

  function automatic logic [55:0] pc1(logic [63:0] x);
    logic [55:0] res = '0;
    for (int i = 0; i < 56; i++) res[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return res;
  endfunction

  function automatic logic [47:0] pc2(logic [55:0] x);
    logic [47:0] res = '0;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return res;
  endfunction

  function automatic logic [47:0] expand(logic [31:0] x);
    logic [47:0] res = '0;
    for (int i = 0; i < 48; i++) res[6'(47 - i)] = x[5'(32 - E_T[i])];
    return res;
  endfunction

  function automatic logic [31:0] perm_p(logic [31:0] x);
    logic [31:0] res = '0;
    for (int i = 0; i < 32; i++) res[5'(31 - i)] = x[5'(32 - P_T[i])];
    return res;
  endfunction

  function automatic logic [31:0] sbox_sub(logic [47:0] x);
    logic [31:0] res = '0;
    logic [5:0]  six;
    for (int j = 0; j < 8; j++) begin
      six = x[6'(47 - 6 * j) -: 6];
      // Row is outer bits, column the inner four.
      res[5'(31 - 4 * j) -: 4] = SBOX[3'(j)][{six[5], six[0], six[4:1]}];
    end
    return res;
  endfunction

  function automatic logic [27:0] rol28(logic [27:0] x, logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] ror28(logic [27:0] x, logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_iter_sequencer_if.sv
// Host-side job input and result output handshake bundle.
interface des_iter_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [63:0] in_block;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;

  modport master (
    output in_valid, in_decrypt, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_decrypt, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/des_round_f.sv
// DES f-function: expansion, subkey XOR, S-boxes, P permutation. Purely combinational.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  assign f = perm_p(sbox_sub(expand(r) ^ k));

endmodule

// File: rtl/des_iter_sequencer.sv
// Iterative DES: IP, 16 rounds over one shared f-function, on-the-fly key schedule, FP.
module des_iter_sequencer
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  des_iter_sequencer_if.slave   bus,
  output logic                  busy,
  output logic [3:0]            round_idx
);

  state_e       state_q, state_d;
  logic [31:0]  l_q, l_d, r_q, r_d;
  logic [27:0]  c_q, c_d, d_q, d_d;
  logic [27:0]  c_rot, d_rot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic [63:0]  out_block_q, out_block_d;
  logic [1:0]   amt;
  logic [47:0]  subkey;
  logic [31:0]  f;

  // Key schedule: decrypt round 1 reuses C0,D0 unrotated, later rounds rotate right.
  always_comb begin
    amt = shift_of(5'(cnt_q));
    if (mode_q) begin
      amt   = (cnt_q == CNT_W'(1)) ? 2'd0 : shift_of(5'(5'd18 - 5'(cnt_q)));
      c_rot = ror28(c_q, amt);
      d_rot = ror28(d_q, amt);
    end else begin
      c_rot = rol28(c_q, amt);
      d_rot = rol28(d_q, amt);
    end
    subkey = pc2({c_rot, d_rot});
  end

  des_round_f u_round_f (
    .r (r_q),
    .k (subkey),
    .f (f)
  );

  assign bus.out_block = out_block_q;

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    l_d           = l_q;
    r_d           = r_q;
    c_d           = c_q;
    d_d           = d_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    out_block_d   = out_block_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    round_idx     = '0;
    unique case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          {l_d, r_d} = ip(bus.in_block);
          {c_d, d_d} = pc1(bus.in_key);
          mode_d     = bus.in_decrypt;
          cnt_d      = CNT_W'(1);
          state_d    = StRound;
        end
      end
      StRound: begin
        busy      = 1'b1;
        round_idx = 4'(cnt_q - CNT_W'(1));
        c_d       = c_rot;
        d_d       = d_rot;
        l_d       = r_q;
        r_d       = l_q ^ f;
        if (cnt_q == CNT_W'(ROUNDS)) begin
          // Final swap folded in: FP({R16, L16}) with R16 = l_q ^ f, L16 = r_q.
          out_block_d = fp({l_q ^ f, r_q});
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_block_q <= out_block_d;
    end
  end

endmodule

// File: tb/tb_des_iter_sequencer.sv
// Scoreboard bench for des_iter_sequencer: stimulus pushes expected results, a
// negedge monitor pops and compares on each output handshake.
module tb_des_iter_sequencer;
  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K3  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K3P = 64'h0F339333EB6C0C72;
  localparam logic [63:0] PT3 = 64'h8787878787878787;
  localparam logic [63:0] CT3 = 64'h0000000000000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] round_idx;

  des_iter_sequencer_if bus ();

  des_iter_sequencer #(.ROUNDS(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc_last = 0;
  logic [63:0] exp_q [$];
  int          acc_q [$];
  logic        ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Monitor: latency on each rising out_valid, result on each handshake, round index in ROUND.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !ov_prev) begin
        if (acc_q.size() == 0) fail("latency_no_job");
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'd17);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h required no output", bus.out_block);
        end else begin
          check("out_block", bus.out_block, exp_q.pop_front());
        end
      end
      if (busy && !bus.out_valid) begin
        check("round_idx", 64'(round_idx), 64'(cyc - acc_last - 1));
        check("in_ready_round", 64'(bus.in_ready), 64'd0);
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic send(input logic [63:0] blk, input logic [63:0] key, input logic dec,
                      input logic [63:0] req);
    int w = 0;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_block   = blk;
    bus.in_key     = key;
    bus.in_decrypt = dec;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      fail("accept_timeout");
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(req);
      acc_q.push_back(cyc);
      acc_last = cyc;
      @(posedge clk);
      #1;
      // Post-accept changes must not affect the job.
      bus.in_valid   = 1'b0;
      bus.in_decrypt = ~dec;
      bus.in_key     = ~key;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((exp_q.size() != 0 || busy) && w < 300);
    if (exp_q.size() != 0 || busy) fail("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int a0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_decrypt = 1'b0;
    bus.in_block   = '0;
    bus.in_key     = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    check("rst_out_block", bus.out_block, 64'd0);
    rst = 1'b0;

    // Vectors 1-3: encrypt, decrypt, second key with and without parity flipped.
    send(PT1, K1, 1'b0, CT1);
    wait_idle();
    send(CT1, K1, 1'b1, PT1);
    wait_idle();
    send(PT3, K3, 1'b0, CT3);
    send(PT3, K3P, 1'b0, CT3);
    wait_idle();

    // Output stall: result held, in_ready low, extra in_valid ignored.
    bus.out_ready = 1'b0;
    send(PT1, K1, 1'b0, CT1);
    w = 0;
    while (!bus.out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) fail("stall_wait_valid");
    bus.in_valid = 1'b1;
    bus.in_block = PT3;
    bus.in_key   = K3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_block", bus.out_block, CT1);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_busy", 64'(busy), 64'd0);
    check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
    send(CT1, K1, 1'b1, PT1);
    wait_idle();

    // Abort at round 8.
    send(PT1, K1, 1'b0, CT1);
    w = 0;
    while (!(busy && round_idx == 4'd7) && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!(busy && round_idx == 4'd7)) fail("abort_wait_round8");
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    send(PT1, K1, 1'b0, CT1);
    wait_idle();

    // Back-to-back with out_ready high: 18-cycle spacing.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a0 = acc_last;
      if (i % 2 == 0) send(PT1, K1, 1'b0, CT1);
      else            send(CT1, K1, 1'b1, PT1);
      if (i > 0) check("b2b_spacing", 64'(acc_last - a0), 64'd18);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
